// File: rtl/dec1_timer_if.sv
// Load handshake bundle for dec1_timer: the host offers a period value and the timer accepts it.
// The host drives valid/value through master; the timer answers with ready through slave.
interface dec1_timer_if #(
  parameter int WIDTH = 24
);
  logic             load_valid;
  logic             load_ready;
  logic [WIDTH-1:0] load_value;

  modport master (
    output load_valid,
    output load_value,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_value,
    output load_ready
  );
endinterface

// File: rtl/dec1_timer.sv
// Programmable down-counting timer with a grouped borrow-lookahead decrement-by-one datapath,
// one-cycle expire pulse on underflow and optional auto-reload for periodic operation.
//
// state | meaning
// IDLE  | waiting for a period load; count holds its last value
// RUN   | counting down on each tick; loads are refused
// DONE  | one-shot count finished; count is 0; a new load restarts
module dec1_timer #(
  parameter int WIDTH = 24
) (
  input  logic             clk,
  input  logic             rst,
  dec1_timer_if.slave      load,
  input  logic             reload_en,
  input  logic             tick,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             expire
);

  localparam int NGROUPS = WIDTH / 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] borrow_mask;
  logic [WIDTH-1:0] dec_value;
  logic [NGROUPS:0] group_borrow;
  logic             borrow_out;

  // Each 4-bit group resolves its own mask from the incoming group borrow,
  // so the long path is one AND per group rather than one per bit.
  assign group_borrow[0] = 1'b1;

  for (genvar g = 0; g < NGROUPS; g++) begin : g_dec_group
    logic [3:0] nib;
    assign nib = count[4*g +: 4];

    assign borrow_mask[4*g + 0] = group_borrow[g];
    assign borrow_mask[4*g + 1] = group_borrow[g] & ~nib[0];
    assign borrow_mask[4*g + 2] = group_borrow[g] & ~nib[0] & ~nib[1];
    assign borrow_mask[4*g + 3] = group_borrow[g] & ~nib[0] & ~nib[1] & ~nib[2];

    assign group_borrow[g+1] = group_borrow[g] & ~nib[0] & ~nib[1] & ~nib[2] & ~nib[3];
  end

  assign dec_value  = count ^ borrow_mask;
  assign borrow_out = group_borrow[NGROUPS];

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      expire     <= 1'b0;
    end else begin
      expire <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (load.load_valid) begin
            count      <= load.load_value;
            reload_reg <= load.load_value;
            state      <= RUN;
          end
        end
        RUN: begin
          // stop wins over tick, so an abort at count 0 never fires expire
          if (stop) begin
            state <= IDLE;
          end else if (tick) begin
            if (borrow_out) begin
              expire <= 1'b1;
              if (reload_en) begin
                count <= reload_reg;
              end else begin
                state <= DONE;
              end
            end else begin
              count <= dec_value;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign load.load_ready = (state != RUN);
  assign busy            = (state == RUN);
  assign done            = (state == DONE);

endmodule

// File: tb/tb_dec1_timer.sv
// Directed and randomized bench for dec1_timer, checked against a behavioural model
// that advances the period/expire rules once per clock edge.
module tb_dec1_timer;
  localparam int WIDTH = 24;

  logic             clk = 1'b0;
  logic             rst;
  logic             reload_en;
  logic             tick;
  logic             stop;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             expire;

  dec1_timer_if #(.WIDTH(WIDTH)) load_bus ();

  dec1_timer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load_bus.slave),
    .reload_en (reload_en),
    .tick      (tick),
    .stop      (stop),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .expire    (expire)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // reference model: running / finished flags plus the period arithmetic
  bit               m_running;
  bit               m_finished;
  logic [WIDTH-1:0] m_count;
  logic [WIDTH-1:0] m_period;
  bit               m_expire;

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic model_edge();
    if (rst) begin
      m_running  = 0;
      m_finished = 0;
      m_count    = '0;
      m_period   = '0;
      m_expire   = 0;
    end else begin
      m_expire = 0;
      if (!m_running) begin
        if (load_bus.load_valid) begin
          m_count    = load_bus.load_value;
          m_period   = load_bus.load_value;
          m_running  = 1;
          m_finished = 0;
        end
      end else if (stop) begin
        m_running = 0;
      end else if (tick) begin
        if (m_count == 0) begin
          m_expire = 1;
          if (reload_en) begin
            m_count = m_period;
          end else begin
            m_running  = 0;
            m_finished = 1;
          end
        end else begin
          m_count = m_count - 1;
        end
      end
    end
  endtask

  // one clock: model follows the edge, outputs sampled 1 time unit later
  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".count"},      32'(count),              32'(m_count));
    check({tag, ".expire"},     32'(expire),             32'(m_expire));
    check({tag, ".busy"},       32'(busy),               32'(m_running));
    check({tag, ".done"},       32'(done),               32'(m_finished));
    check({tag, ".load_ready"}, 32'(load_bus.load_ready), 32'(!m_running));
  endtask

  task automatic drive(input bit r, input bit lv, input logic [WIDTH-1:0] lval,
                       input bit ren, input bit tk, input bit sp);
    rst                 = r;
    load_bus.load_valid = lv;
    load_bus.load_value = lval;
    reload_en           = ren;
    tick                = tk;
    stop                = sp;
  endtask

  initial begin
    int first_exp;
    int n_exp;
    int k;
    drive(1, 0, '0, 0, 0, 0);
    #1;

    // reset for two cycles
    step("rst0");
    step("rst1");
    check("rst.count", 32'(count), 32'h0);
    check("rst.load_ready", 32'(load_bus.load_ready), 32'h1);

    // load 3 with tick held: expire in the 5th cycle after the load
    drive(0, 1, 24'h000003, 0, 1, 0);
    step("load3");
    check("load3.count", 32'(count), 32'h3);
    drive(0, 0, '0, 0, 1, 0);
    first_exp = 0;
    n_exp = 0;
    for (int i = 1; i <= 7; i++) begin
      step("run3");
      if (expire) begin
        n_exp++;
        if (first_exp == 0) first_exp = i + 1;
      end
    end
    check("run3.expire_cycle", 32'(first_exp), 32'd5);
    check("run3.expire_count", 32'(n_exp), 32'd1);
    check("run3.done", 32'(done), 32'h1);

    // borrow across group boundaries
    drive(0, 1, 24'h100000, 0, 0, 0); step("ld100000");
    drive(0, 0, '0, 0, 1, 0);         step("tk100000");
    check("ripple.0FFFFF", 32'(count), 32'h0FFFFF);
    drive(0, 0, '0, 0, 0, 1);         step("stopA");
    drive(0, 1, 24'h000010, 0, 0, 0); step("ld10");
    drive(0, 0, '0, 0, 1, 0);         step("tk10");
    check("ripple.0F", 32'(count), 32'h00000F);
    drive(0, 0, '0, 0, 0, 1);         step("stopB");
    drive(0, 1, 24'hFFFFFF, 0, 0, 0); step("ldFFFFFF");
    drive(0, 0, '0, 0, 1, 0);         step("tkF1");
    check("ripple.FFFFFE", 32'(count), 32'hFFFFFE);
    step("tkF2");
    check("ripple.FFFFFD", 32'(count), 32'hFFFFFD);
    // load ignored while running
    drive(0, 1, 24'h000055, 0, 0, 0); step("ld_in_run");
    check("ld_in_run.count", 32'(count), 32'hFFFFFD);
    drive(0, 0, '0, 0, 0, 1);         step("stopC");

    // auto-reload with period 3
    drive(0, 1, 24'd2, 1, 0, 0); step("ld2");
    drive(0, 0, '0, 1, 1, 0);
    n_exp = 0;
    for (int i = 0; i < 12; i++) begin
      step("reload2");
      if (expire) n_exp++;
    end
    check("reload2.expires", 32'(n_exp), 32'd4);
    check("reload2.busy", 32'(busy), 32'h1);
    drive(0, 0, '0, 0, 0, 1); step("stopD");

    // gated tick
    drive(0, 1, 24'd5, 0, 0, 0); step("ld5");
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, '0, 0, (i % 2) == 0, 0);
      step("gated");
    end
    check("gated.count", 32'(count), 32'd2);

    // stop at count 0 with tick
    drive(0, 0, '0, 0, 1, 0); step("to1"); step("to0");
    check("stop0.pre", 32'(count), 32'd0);
    drive(0, 0, '0, 0, 1, 1); step("stop0");
    check("stop0.expire", 32'(expire), 32'h0);
    check("stop0.idle", 32'({busy, done}), 32'h0);

    // load 0 with reload: expire every ticked cycle
    drive(0, 1, 24'd0, 1, 0, 0); step("ld0");
    drive(0, 0, '0, 1, 1, 0);
    n_exp = 0;
    for (int i = 0; i < 4; i++) begin
      step("n0");
      if (expire) n_exp++;
    end
    check("n0.expires", 32'(n_exp), 32'd4);

    // reset on the underflow cycle
    drive(1, 0, '0, 1, 1, 0); step("rst_uf");
    check("rst_uf.expire", 32'(expire), 32'h0);

    // reset mid-run at count 7
    drive(0, 1, 24'd9, 0, 0, 0); step("ld9");
    drive(0, 0, '0, 0, 1, 0); step("t8"); step("t7");
    check("mid.pre", 32'(count), 32'd7);
    drive(1, 0, '0, 0, 1, 0); step("rst_mid");
    check("mid.count", 32'(count), 32'd0);
    check("mid.ready", 32'(load_bus.load_ready), 32'h1);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 3);
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 3) == 0),
            (k == 0) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 6)),
            $urandom_range(0, 1),
            ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0));
      step("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dec1_timer.md
# dec1_timer

Programmable 24-bit down-counting timer built around a borrow-lookahead decrement-by-one datapath, the subtractive counterpart of the increment-by-one block. The host loads a period through a valid/ready handshake. The counter then decrements on each qualified `tick` and raises a one-cycle `expire` pulse when it underflows past zero. It can optionally auto-reload for periodic operation. It sits beside the incrementer in the arithmetic/control library and serves as the shared timeout and interval generator.

## Interface
- `WIDTH`, default 24: counter width. Must be a multiple of 4, because the decrementer is built from 4-bit lookahead groups.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `load_valid`  in  1  host offers `load_value`.
- `load_ready`  out  1  block can accept a load; equals (state != RUN).
- `load_value`  in  WIDTH  period value N; period = N+1 ticks.
- `reload_en`  in  1  auto-reload on underflow; sampled every cycle.
- `tick`  in  1  decrement enable; sampled every cycle.
- `stop`  in  1  abort the running count.
- `count`  out  WIDTH  current counter register.
- `busy`  out  1  state == RUN.
- `done`  out  1  state == DONE.
- `expire`  out  1  registered one-cycle underflow pulse.

## Operation
- Decrement datapath:
  - Borrow mask: m[0]=1 and m[i] = AND of ~count[i-1:0].
  - Next value = count XOR m.
  - Borrow-out = AND of ~count.
  - Computed in WIDTH/4 groups of 4 bits. Each group produces a group-borrow that is forwarded to the next group.
  - Pure combinational; wrap 0 -> all-ones is never written to `count` (see RUN below).
- Registers: `state` {IDLE, RUN, DONE}, `count`, `reload_reg`, `expire`.
- IDLE:
  - On `load_valid`=1: `count` and `reload_reg` <= `load_value`, then -> RUN.
  - Otherwise hold.
- RUN, priority `stop` > `tick`:
  - `stop`=1: -> IDLE. `count` is held and no `expire` is generated, even if `tick`=1 at count 0.
  - `tick`=1, count != 0: `count` <= count-1.
  - `tick`=1, count == 0 (borrow-out=1): `expire` <= 1.
    - If `reload_en`=1: `count` <= `reload_reg`, stay in RUN.
    - If `reload_en`=0: `count` stays 0, -> DONE.
  - `tick`=0: hold.
  - `load_valid` is ignored in RUN (`load_ready`=0).
- DONE:
  - `count`=0.
  - On `load_valid`=1: behaves as the IDLE load, -> RUN.
  - `stop` has no effect.
- `expire` is cleared every cycle unless set by an underflow.
- Edge cases:
  - Loading N=0 gives one expire per tick.
  - `reload_reg`=0 with `reload_en`=1 gives an expire on every ticked cycle.
- `rst` overrides everything on the same edge, including an in-flight load or underflow.

## Timing
- Reset values:
  - state=IDLE, count=0, reload_reg=0, expire=0.
  - Hence busy=0, done=0, load_ready=1.
- Load handshake:
  - Transfer occurs on a rising edge with `load_valid`=1 and `load_ready`=1.
  - `busy`=1 and `count`=N from the next cycle.
- Latency:
  - `count` reflects a tick one cycle after the tick edge.
  - `expire` is high during the cycle following the tick at count 0.
  - `done` rises in that same cycle.
- Period:
  - Load N, then continuous tick: `expire` occurs N+1 cycles after the first ticked cycle.
  - With reload, repeats every N+1 ticked cycles, with no gap cycle.
- Outputs:
  - `load_ready`, `busy` and `done` are decoded from registered state only.
  - No combinational path from inputs to outputs.
- Critical path: decrement through WIDTH/4 group borrows. Must close at the library target frequency for WIDTH=24.

## Test plan
- Reset then load:
  - `rst` for 2 cycles: count=0, load_ready=1, expire=0.
  - Load 0x000003 with tick held 1: count 3,2,1,0; expire high for exactly one cycle on the 5th cycle after load; then done=1, load_ready=1, count=0.
- Borrow ripple across groups:
  - Load 0x100000, one tick: count=0x0FFFFF.
  - Load 0x000010, one tick: count=0x00000F.
  - Load 0xFFFFFF, ticks continue: count=0xFFFFFE, then 0xFFFFFD.
- Auto-reload:
  - Load 2, reload_en=1, continuous tick: expire every 3rd cycle for 4 periods; count sequence 2,1,0,2,1,0…; busy stays 1.
- Gated tick and stop:
  - Load 5, tick alternating 1/0: count decrements only on ticked cycles.
  - Assert stop with count=0 and tick=1: expire stays 0, state=IDLE, count holds 0.
- Handshake and edge cases:
  - load_valid during RUN: ignored, count unaffected.
  - Load 0 with reload_en=1: expire on every ticked cycle.
- Reset mid-operation:
  - `rst` during RUN at count=7: all outputs return to reset values the next cycle.
  - Reset on the underflow cycle: no expire pulse.
